// File: rtl/bus_frame_pkg.sv
// Shared definitions for the time-multiplexed pad frame interface.
// Provides the slot index type, the slot-end / frame-end decode helpers and
// the default slot length code used after reset.
package bus_frame_pkg;

    // Slot length code in force after reset (slot lasts DEF_LEN_C+1 cycles).
    localparam int DEF_LEN_C = 0;

    typedef int unsigned slot_num_t;

    // Last cycle of the current slot.
    function automatic logic slot_end_f(input logic ena, input int unsigned sub,
                                        input int unsigned len);
        return ena && (sub == len);
    endfunction

    // Last cycle of the last slot, i.e. the frame boundary.
    function automatic logic frame_end_f(input logic ena, input slot_num_t slot,
                                         input slot_num_t last_slot,
                                         input int unsigned sub, input int unsigned len);
        return slot_end_f(ena, sub, len) && (slot == last_slot);
    endfunction

endpackage

// File: rtl/bus_frame_timer.sv
// Slot / sub-slot counters for the pad frame.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ena_i           global enable; 0 freezes the counters
//   slot_len_i      requested slot length code, latched only at frame end
//   slot_o          current slot index
//   frame_sync_o    first cycle of slot 0
//   slot_end_o      last cycle of the current slot (qualified by ena_i)
//   frame_end_o     last cycle of the last slot (qualified by ena_i)
module bus_frame_timer
    import bus_frame_pkg::*;
#(
    parameter int NUM_SLOTS = 3,
    parameter int DIV_W     = 4,
    parameter int DEF_LEN   = DEF_LEN_C,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    input  logic [DIV_W-1:0]  slot_len_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              frame_sync_o,
    output logic              slot_end_o,
    output logic              frame_end_o
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DIV_W-1:0]  sub_q, sub_d;
    logic [DIV_W-1:0]  len_q, len_d;
    logic              slot_end;
    logic              frame_end;

    always_comb begin
        slot_end  = slot_end_f(ena_i, 32'(sub_q), 32'(len_q));
        frame_end = frame_end_f(ena_i, slot_num_t'(slot_q), slot_num_t'(NUM_SLOTS - 1),
                                32'(sub_q), 32'(len_q));
        slot_d = slot_q;
        sub_d  = sub_q;
        len_d  = len_q;
        if (ena_i) begin
            if (slot_end) begin
                sub_d  = '0;
                slot_d = frame_end ? '0 : slot_q + SLOT_W'(1);
            end else begin
                sub_d = sub_q + DIV_W'(1);
            end
        end
        // Length changes only at the frame boundary so a frame never mixes lengths.
        if (frame_end) begin
            len_d = slot_len_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            sub_q  <= '0;
            len_q  <= DIV_W'(DEF_LEN);
        end else begin
            slot_q <= slot_d;
            sub_q  <= sub_d;
            len_q  <= len_d;
        end
    end

    assign slot_o       = slot_q;
    assign frame_sync_o = (slot_q == '0) && (sub_q == '0);
    assign slot_end_o   = slot_end;
    assign frame_end_o  = frame_end;

endmodule

// File: rtl/bus_frame_mux.sv
// Time-multiplexed pad interface: drives one OUT_W slice of a frame snapshot
// per slot, generates the divided core clock with edge strobes and samples a
// returned pad byte in the last cycle of slot IN_SLOT.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ena                     global enable; 0 freezes all state, clears pulses
//   hold                    suppresses the core clock toggle at frame end
//   slot_len                slot length code (slot_len+1 cycles per slot)
//   frame_in                core status vector, slice k goes out in slot k
//   pad_in                  returned pad byte
//   out_data, slot_idx      pad output and current slot
//   frame_sync              first cycle of slot 0
//   core_clk/rise/fall      divided core clock and its edge strobes
//   in_data, in_valid       last sampled pad byte and its update pulse
module bus_frame_mux
    import bus_frame_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter int NUM_SLOTS = 3,
    parameter int DIV_W     = 4,
    parameter int DEF_LEN   = DEF_LEN_C,
    parameter int IN_SLOT   = 0,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       hold,
    input  logic [DIV_W-1:0]           slot_len,
    input  logic [NUM_SLOTS*OUT_W-1:0] frame_in,
    input  logic [OUT_W-1:0]           pad_in,
    output logic [OUT_W-1:0]           out_data,
    output logic [SLOT_W-1:0]          slot_idx,
    output logic                       frame_sync,
    output logic                       core_clk,
    output logic                       core_rise,
    output logic                       core_fall,
    output logic [OUT_W-1:0]           in_data,
    output logic                       in_valid
);

    logic [SLOT_W-1:0]          slot;
    logic                       slot_end;
    logic                       fe;
    logic                       sample;

    logic [NUM_SLOTS*OUT_W-1:0] snap_q, snap_d;
    logic                       core_clk_q, core_clk_d;
    logic                       core_rise_q, core_rise_d;
    logic                       core_fall_q, core_fall_d;
    logic [OUT_W-1:0]           in_data_q, in_data_d;
    logic                       in_valid_q, in_valid_d;

    bus_frame_timer #(
        .NUM_SLOTS (NUM_SLOTS),
        .DIV_W     (DIV_W),
        .DEF_LEN   (DEF_LEN),
        .SLOT_W    (SLOT_W)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena_i        (ena),
        .slot_len_i   (slot_len),
        .slot_o       (slot),
        .frame_sync_o (frame_sync),
        .slot_end_o   (slot_end),
        .frame_end_o  (fe)
    );

    assign sample = slot_end && (slot == SLOT_W'(IN_SLOT));

    always_comb begin
        snap_d      = snap_q;
        core_clk_d  = core_clk_q;
        core_rise_d = 1'b0;
        core_fall_d = 1'b0;
        in_data_d   = in_data_q;
        in_valid_d  = 1'b0;
        // Whole-frame snapshot keeps the pad slices of one frame coherent.
        if (fe) begin
            snap_d = frame_in;
            if (!hold) begin
                core_clk_d  = ~core_clk_q;
                core_rise_d = ~core_clk_q;
                core_fall_d = core_clk_q;
            end
        end
        if (sample) begin
            in_data_d  = pad_in;
            in_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q      <= '0;
            core_clk_q  <= 1'b0;
            core_rise_q <= 1'b0;
            core_fall_q <= 1'b0;
            in_data_q   <= '0;
            in_valid_q  <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            core_clk_q  <= core_clk_d;
            core_rise_q <= core_rise_d;
            core_fall_q <= core_fall_d;
            in_data_q   <= in_data_d;
            in_valid_q  <= in_valid_d;
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot == SLOT_W'(k)) begin
                out_data = snap_q[k*OUT_W +: OUT_W];
            end
        end
    end

    assign slot_idx  = slot;
    assign core_clk  = core_clk_q;
    assign core_rise = core_rise_q;
    assign core_fall = core_fall_q;
    assign in_data   = in_data_q;
    assign in_valid  = in_valid_q;

endmodule

// File: tb/tb_bus_frame_mux.sv
module tb_bus_frame_mux;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        hold;
    logic [3:0]  slot_len;
    logic [23:0] frame_in;
    logic [7:0]  pad_in;
    logic [7:0]  out_data;
    logic [1:0]  slot_idx;
    logic        frame_sync;
    logic        core_clk;
    logic        core_rise;
    logic        core_fall;
    logic [7:0]  in_data;
    logic        in_valid;

    int n_pass  = 0;
    int n_total = 0;

    bus_frame_mux #(.IN_SLOT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .hold       (hold),
        .slot_len   (slot_len),
        .frame_in   (frame_in),
        .pad_in     (pad_in),
        .out_data   (out_data),
        .slot_idx   (slot_idx),
        .frame_sync (frame_sync),
        .core_clk   (core_clk),
        .core_rise  (core_rise),
        .core_fall  (core_fall),
        .in_data    (in_data),
        .in_valid   (in_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [22:0] obs;
    assign obs = {out_data, slot_idx, frame_sync, core_clk, core_rise, core_fall, in_data, in_valid};

    localparam logic [22:0] RST_VEC = {8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    // Reference model: a frame is 3*(len+1) cycles, tracked as a position in the frame.
    int          m_pos;
    int          m_len;
    logic [23:0] m_snap;
    logic        m_cclk, m_rise, m_fall, m_inv;
    logic [7:0]  m_in;

    task automatic model_reset();
        m_pos = 0; m_len = 0; m_snap = '0;
        m_cclk = 0; m_rise = 0; m_fall = 0; m_in = '0; m_inv = 0;
    endtask

    task automatic model_step();
        int L, slot;
        bit last_cycle, fe;
        L = m_len + 1;
        slot = m_pos / L;
        last_cycle = (m_pos % L) == m_len;
        fe = (m_pos == 3 * L - 1);
        m_rise = 0; m_fall = 0; m_inv = 0;
        if (ena) begin
            if (last_cycle && slot == 2) begin
                m_in = pad_in;
                m_inv = 1;
            end
            if (fe) begin
                m_snap = frame_in;
                m_len = int'(slot_len);
                m_pos = 0;
                if (!hold) begin
                    m_rise = !m_cclk;
                    m_fall = m_cclk;
                    m_cclk = !m_cclk;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    function automatic logic [22:0] exp_vec();
        int s;
        s = m_pos / (m_len + 1);
        return {m_snap[s*8 +: 8], 2'(s), (m_pos == 0), m_cclk, m_rise, m_fall, m_in, m_inv};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic sync_frame();
        int n = 0;
        do begin
            tick();
            n++;
        end while (m_pos != 0 && n < 200);
    endtask

    logic [7:0] seq_out [9] = '{8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'h03, 8'hEF, 8'hBE, 8'h03};
    logic       seq_clk [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] seq_slot [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};

    task automatic test_reset();
        rst_n = 0; ena = 1; hold = 0; slot_len = 4'd0; frame_in = 24'h03BEEF; pad_in = 8'h00;
        model_reset();
        #1;
        n_total++;
        if (obs !== RST_VEC) $display("FAIL reset_async obs=%h exp=%h", obs, RST_VEC);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (obs !== RST_VEC) $display("FAIL reset_held obs=%h exp=%h", obs, RST_VEC);
        else n_pass++;
    endtask

    task automatic test_default();
        rst_n = 1;
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (out_data !== seq_out[i]) $display("FAIL default_out[%0d] got=%h exp=%h", i, out_data, seq_out[i]);
            else n_pass++;
            n_total++;
            if (core_clk !== seq_clk[i]) $display("FAIL default_clk[%0d] got=%b exp=%b", i, core_clk, seq_clk[i]);
            else n_pass++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL default_model[%0d] obs=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_snapshot();
        sync_frame();
        frame_in = 24'h0000AA;
        tick(); tick(); tick();
        n_total++;
        if (out_data !== 8'hAA) $display("FAIL snap_aa got=%h exp=aa", out_data);
        else n_pass++;
        tick();
        frame_in = 24'h0000BB;
        tick();
        n_total++;
        if (obs !== exp_vec()) $display("FAIL snap_mid obs=%h exp=%h", obs, exp_vec());
        else n_pass++;
        tick();
        n_total++;
        if (out_data !== 8'hBB) $display("FAIL snap_bb got=%h exp=bb", out_data);
        else n_pass++;
    endtask

    task automatic test_hold();
        int strobes;
        frame_in = 24'h123456;
        sync_frame();
        hold = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++;
            if ((core_rise | core_fall) !== 1'b0 || core_clk !== m_cclk)
                $display("FAIL hold_frozen[%0d] clk=%b rise=%b fall=%b exp_clk=%b", i, core_clk, core_rise, core_fall, m_cclk);
            else n_pass++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL hold_model[%0d] obs=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
        end
        hold = 0;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            strobes += int'(core_rise) + int'(core_fall);
        end
        n_total++;
        if (strobes !== 1) $display("FAIL hold_resume strobes=%0d exp=1", strobes);
        else n_pass++;
    endtask

    task automatic test_input_sample();
        sync_frame();
        pad_in = 8'h11;
        tick(); tick();
        pad_in = 8'h5A;
        tick();
        n_total++;
        if (in_data !== 8'h5A || in_valid !== 1'b1)
            $display("FAIL sample_5a in_data=%h in_valid=%b exp=5a/1", in_data, in_valid);
        else n_pass++;
        pad_in = 8'hC3;
        tick();
        n_total++;
        if (in_data !== 8'h5A || in_valid !== 1'b0)
            $display("FAIL sample_pulse in_data=%h in_valid=%b exp=5a/0", in_data, in_valid);
        else n_pass++;
        ena = 0;
        for (int i = 0; i < 5; i++) begin
            pad_in = 8'($urandom);
            frame_in = 24'($urandom);
            tick();
            n_total++;
            if ((core_rise | core_fall | in_valid) !== 1'b0)
                $display("FAIL ena_pulses[%0d] rise=%b fall=%b valid=%b exp=0", i, core_rise, core_fall, in_valid);
            else n_pass++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL ena_frozen[%0d] obs=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
        end
        ena = 1;
    endtask

    task automatic test_len_change();
        int cnt;
        sync_frame();
        tick();
        slot_len = 4'd2;
        tick();
        n_total++;
        if (slot_idx !== 2'd2) $display("FAIL len_kept slot=%0d exp=2", slot_idx);
        else n_pass++;
        cnt = 0;
        while (!(core_rise || core_fall) && cnt < 40) begin
            tick();
            cnt++;
        end
        cnt = 0;
        do begin
            tick();
            cnt++;
            n_total++;
            if (obs !== exp_vec()) $display("FAIL len_model[%0d] obs=%h exp=%h", cnt, obs, exp_vec());
            else n_pass++;
        end while (!(core_rise || core_fall) && cnt < 40);
        n_total++;
        if (cnt !== 9) $display("FAIL len_half_period got=%0d exp=9", cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        int r;
        for (int i = 0; i < 300; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            hold = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 7));
            slot_len = (r == 7) ? 4'hF : 4'(r % 3);
            frame_in = 24'($urandom);
            pad_in = 8'($urandom);
            tick();
            n_total++;
            if (obs !== exp_vec()) begin
                errs++;
                if (errs < 10) $display("FAIL random[%0d] obs=%h exp=%h", i, obs, exp_vec());
            end else n_pass++;
        end
        ena = 1; hold = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        slot_len = 4'd3;
        while (!(m_len == 3 && m_pos == 5) && n < 200) begin
            tick();
            n++;
        end
        @(posedge clk);
        model_step();
        #2;
        rst_n = 0;
        #1;
        n_total++;
        if (obs !== RST_VEC) $display("FAIL reset_mid obs=%h exp=%h", obs, RST_VEC);
        else n_pass++;
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (slot_idx !== seq_slot[i] || obs !== exp_vec())
                $display("FAIL post_reset[%0d] slot=%0d exp_slot=%0d obs=%h exp=%h", i, slot_idx, seq_slot[i], obs, exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_snapshot();
        test_hold();
        test_input_sample();
        test_len_change();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
